// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StGetFun,
    StIssue,
    StWaitRes,
    StSend
  } seq_state_e;

  localparam logic [7:0] CMD_ARITH = 8'hCC;
  localparam logic [7:0] DIV0_CODE = 8'hFF;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Byte receive, arithmetic-unit and byte transmit signals of the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_FUN_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]    RX_DATA;
  logic                     RX_VALID;
  logic [DATA_WIDTH-1:0]    A;
  logic [DATA_WIDTH-1:0]    B;
  logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
  logic                     Arith_Enable;
  logic [DATA_WIDTH-1:0]    Arith_OUT;
  logic                     OUT_VALID;
  logic [DATA_WIDTH-1:0]    TX_DATA;
  logic                     TX_VALID;
  logic                     TX_READY;
  logic                     BUSY;
  logic                     FRAME_ERR;

  modport slave (
    input  RX_DATA, RX_VALID, Arith_OUT, OUT_VALID, TX_READY,
    output A, B, ALU_FUN, Arith_Enable, TX_DATA, TX_VALID, BUSY, FRAME_ERR
  );

  modport master (
    output RX_DATA, RX_VALID, Arith_OUT, OUT_VALID, TX_READY,
    input  A, B, ALU_FUN, Arith_Enable, TX_DATA, TX_VALID, BUSY, FRAME_ERR
  );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter; expired flags the enabled cycle that consumes the last count.
module seq_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             enable,
  output logic             expired
);
  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (enable && cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  assign expired = enable && (cnt_q == Width'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Parses CMD/A/B/FUN byte frames, issues one arithmetic request and returns the result byte.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_FUN_WIDTH = 2,
  parameter int unsigned GAP_CYCLES    = 64,
  parameter int unsigned RES_TIMEOUT   = 4
) (
  input logic                CLK,
  input logic                RST,
  alu_op_sequencer_if.slave  bus
);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ResW = $clog2(RES_TIMEOUT + 1);

  seq_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     gap_load, gap_en, gap_expired;
  logic                     res_load, res_en, res_expired;
  logic                     in_frame;

  assign in_frame = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetFun);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    frame_err_d = 1'b0;
    gap_load    = 1'b0;
    gap_en      = in_frame && !bus.RX_VALID;
    res_load    = 1'b0;
    res_en      = 1'b0;

    // A byte arriving on the expiry cycle still counts; the timeout only fires on idle cycles.
    if (gap_expired) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
    end

    case (state_q)
      StIdle: begin
        if (bus.RX_VALID && bus.RX_DATA == DATA_WIDTH'(CMD_ARITH)) begin
          gap_load = 1'b1;
          state_d  = StGetA;
        end
      end
      StGetA: begin
        if (bus.RX_VALID) begin
          a_d      = bus.RX_DATA;
          gap_load = 1'b1;
          state_d  = StGetB;
        end
      end
      StGetB: begin
        if (bus.RX_VALID) begin
          b_d      = bus.RX_DATA;
          gap_load = 1'b1;
          state_d  = StGetFun;
        end
      end
      StGetFun: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA[DATA_WIDTH-1:ALU_FUN_WIDTH] != '0) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end else if (bus.RX_DATA[ALU_FUN_WIDTH-1:0] == ALU_FUN_WIDTH'(FUN_DIV) && b_q == '0) begin
            tx_data_d   = DATA_WIDTH'(DIV0_CODE);
            tx_valid_d  = 1'b1;
            frame_err_d = 1'b1;
            state_d     = StSend;
          end else begin
            fun_d   = bus.RX_DATA[ALU_FUN_WIDTH-1:0];
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        res_load = 1'b1;
        state_d  = StWaitRes;
      end
      StWaitRes: begin
        if (bus.OUT_VALID) begin
          tx_data_d  = bus.Arith_OUT;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else begin
          res_en = 1'b1;
          if (res_expired) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StSend: begin
        if (bus.TX_READY) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  seq_timer #(.Width(GapW)) u_gap_timer (
    .clk      (CLK),
    .rst      (RST),
    .clear    (state_q == StIdle),
    .load     (gap_load),
    .load_val (GapW'(GAP_CYCLES)),
    .enable   (gap_en),
    .expired  (gap_expired)
  );

  seq_timer #(.Width(ResW)) u_res_timer (
    .clk      (CLK),
    .rst      (RST),
    .clear    (state_q == StIdle),
    .load     (res_load),
    .load_val (ResW'(RES_TIMEOUT)),
    .enable   (res_en),
    .expired  (res_expired)
  );

  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.ALU_FUN      = fun_q;
  assign bus.Arith_Enable = (state_q == StIssue);
  assign bus.TX_DATA      = tx_data_q;
  assign bus.TX_VALID     = tx_valid_q;
  assign bus.BUSY         = (state_q != StIdle);
  assign bus.FRAME_ERR    = frame_err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized frames against a byte-level model of the sequencer's responses.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = 2;
  localparam int unsigned GAP = 64;
  localparam int unsigned RTO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_op_sequencer_if #(.DATA_WIDTH(DW), .ALU_FUN_WIDTH(FW)) bus ();

  alu_op_sequencer #(
    .DATA_WIDTH    (DW),
    .ALU_FUN_WIDTH (FW),
    .GAP_CYCLES    (GAP),
    .RES_TIMEOUT   (RTO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic unit behaviour: 8-bit truncated add/sub/mul/div.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] f);
    logic [31:0] r;
    case (f)
      2'd0:    r = 32'(a) + 32'(b);
      2'd1:    r = 32'(a) - 32'(b);
      2'd2:    r = 32'(a) * 32'(b);
      default: r = (b == 8'd0) ? 32'd0 : 32'(a) / 32'(b);
    endcase
    return r[7:0];
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.RX_DATA  = d;
    bus.RX_VALID = 1'b1;
    tick();
    bus.RX_VALID = 1'b0;
  endtask

  task automatic all_outputs_zero(input string tag);
    check(tag, 32'({bus.A, bus.B, bus.ALU_FUN, bus.Arith_Enable, bus.TX_DATA, bus.TX_VALID,
                    bus.BUSY, bus.FRAME_ERR}), 32'd0);
  endtask

  // Holds TX_READY low for bp cycles (with a stray RX byte) and then accepts the response.
  task automatic accept(input logic [7:0] exp, input int bp);
    logic stable = 1'b1;
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin
        bus.RX_DATA  = CMD_ARITH;
        bus.RX_VALID = 1'b1;
      end
      tick();
      bus.RX_VALID = 1'b0;
      if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== exp || bus.BUSY !== 1'b1) stable = 1'b0;
    end
    check("tx_hold", 32'(stable), 32'd1);
    bus.TX_READY = 1'b1;
    tick();
    bus.TX_READY = 1'b0;
    check("tx_done_valid", 32'(bus.TX_VALID), 32'd0);
    check("tx_done_busy", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                           input int gap, input int bp);
    logic [7:0] exp;
    send_byte(CMD_ARITH);
    check("busy_cmd", 32'(bus.BUSY), 32'd1);
    repeat (gap) tick();
    send_byte(a);
    repeat (gap) tick();
    send_byte(b);
    repeat (gap) tick();
    send_byte(f);
    if (f[7:2] != 6'd0) begin
      check("badfun_err", 32'(bus.FRAME_ERR), 32'd1);
      check("badfun_idle", 32'({bus.BUSY, bus.TX_VALID, bus.Arith_Enable}), 32'd0);
      tick();
      check("badfun_pulse", 32'({bus.FRAME_ERR, bus.TX_VALID, bus.Arith_Enable}), 32'd0);
    end else if (f[1:0] == 2'd3 && b == 8'd0) begin
      check("div0_noissue", 32'(bus.Arith_Enable), 32'd0);
      check("div0_err", 32'(bus.FRAME_ERR), 32'd1);
      check("div0_tx", 32'({bus.TX_VALID, bus.TX_DATA}), 32'({1'b1, DIV0_CODE}));
      tick();
      check("div0_pulse", 32'({bus.FRAME_ERR, bus.Arith_Enable}), 32'd0);
      accept(DIV0_CODE, bp > 0 ? bp - 1 : 0);
    end else begin
      exp = alu_ref(a, b, f[1:0]);
      check("issue_en", 32'(bus.Arith_Enable), 32'd1);
      check("issue_ops", 32'({bus.A, bus.B, bus.ALU_FUN}), 32'({a, b, f[1:0]}));
      check("issue_noerr", 32'(bus.FRAME_ERR), 32'd0);
      tick();
      check("wait_en_low", 32'({bus.Arith_Enable, bus.TX_VALID}), 32'd0);
      // The bench acts as a one-cycle arithmetic unit here.
      bus.Arith_OUT = alu_ref(bus.A, bus.B, bus.ALU_FUN);
      bus.OUT_VALID = 1'b1;
      tick();
      bus.OUT_VALID = 1'b0;
      check("res_tx", 32'({bus.TX_VALID, bus.TX_DATA, bus.FRAME_ERR}), 32'({1'b1, exp, 1'b0}));
      accept(exp, bp);
    end
  endtask

  initial begin
    logic       early;
    logic [7:0] ra, rb, rf, junk;

    bus.RX_DATA   = '0;
    bus.RX_VALID  = 1'b0;
    bus.Arith_OUT = '0;
    bus.OUT_VALID = 1'b0;
    bus.TX_READY  = 1'b0;
    RST = 1'b1;
    repeat (2) tick();
    all_outputs_zero("reset_outs");
    RST = 1'b0;
    tick();

    run_frame(8'h12, 8'h34, 8'h00, 0, 2);

    send_byte(8'h55);
    check("hdr_55", 32'({bus.BUSY, bus.FRAME_ERR}), 32'd0);
    send_byte(8'hAA);
    check("hdr_aa", 32'({bus.BUSY, bus.FRAME_ERR}), 32'd0);
    run_frame(8'h07, 8'h03, 8'h01, 0, 0);

    run_frame(8'h09, 8'h00, 8'h03, 0, 1);
    run_frame(8'h01, 8'h02, 8'h04, 0, 0);

    // Inter-byte silence: error exactly GAP cycles after the last byte.
    send_byte(CMD_ARITH);
    send_byte(8'h05);
    early = 1'b0;
    repeat (GAP - 1) begin
      tick();
      if (bus.FRAME_ERR !== 1'b0 || bus.BUSY !== 1'b1) early = 1'b1;
    end
    check("gap_early", 32'(early), 32'd0);
    tick();
    check("gap_err", 32'({bus.FRAME_ERR, bus.BUSY}), 32'b10);
    tick();
    check("gap_pulse", 32'(bus.FRAME_ERR), 32'd0);

    run_frame(8'h11, 8'h22, 8'h00, GAP - 2, 0);

    // Result never arrives.
    send_byte(CMD_ARITH);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h00);
    check("rto_issue", 32'(bus.Arith_Enable), 32'd1);
    early = 1'b0;
    repeat (RTO) begin
      tick();
      if (bus.FRAME_ERR !== 1'b0 || bus.BUSY !== 1'b1) early = 1'b1;
    end
    check("rto_early", 32'(early), 32'd0);
    tick();
    check("rto_err", 32'({bus.FRAME_ERR, bus.BUSY, bus.TX_VALID}), 32'b100);

    run_frame(8'h10, 8'h10, 8'h02, 0, 10);

    // Reset while waiting for the result; a late OUT_VALID must be ignored.
    send_byte(CMD_ARITH);
    send_byte(8'h21);
    send_byte(8'h03);
    send_byte(8'h00);
    tick();
    RST = 1'b1;
    tick();
    all_outputs_zero("rst_waitres");
    RST = 1'b0;
    bus.Arith_OUT = 8'h24;
    bus.OUT_VALID = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0;
    check("late_outvalid", 32'({bus.TX_VALID, bus.BUSY}), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rf = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == CMD_ARITH) junk = 8'h00;
        send_byte(junk);
      end
      run_frame(ra, rb, rf, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
